// File: rtl/ddr3_avl_pkg.sv
// Shared types and constants for the DDR3 Avalon-MM two-port arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ddr3_avl_pkg;

    localparam int DDR3_ADDR_WIDTH = 24;
    localparam int DDR3_DATA_WIDTH = 64;

    localparam logic [6:0] AVL_SIZE_SINGLE = 7'h1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_id_fifo.sv
// Small generic FIFO; holds the issuing-port tag of each outstanding read.
// Latency: push visible at pop_dat next cycle; count/full/empty update next cycle.
// Backpressure: push ignored when full, pop ignored when empty.
module arb_id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/ddr3_avl_arbiter.sv
// Two-port round-robin arbiter onto one DDR3 Avalon-MM local port; read tags route returns.
// Latency: grant to avl request 1 cycle; avl_rdata to pN_rdata 1 cycle.
// Backpressure: command held until avl_ready; reads stall (writes do not) while tag FIFO is full.
module ddr3_avl_arbiter
    import ddr3_avl_pkg::*;
#(
    parameter int ADDR_WIDTH    = DDR3_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DDR3_DATA_WIDTH,
    parameter int RD_FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    p0_cmd_valid,
    input  logic                    p0_cmd_write,
    input  logic [ADDR_WIDTH-1:0]   p0_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   p0_cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] p0_cmd_be,
    output logic                    p0_cmd_ready,
    output logic                    p0_rdata_valid,
    output logic [DATA_WIDTH-1:0]   p0_rdata,
    input  logic                    p1_cmd_valid,
    input  logic                    p1_cmd_write,
    input  logic [ADDR_WIDTH-1:0]   p1_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   p1_cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] p1_cmd_be,
    output logic                    p1_cmd_ready,
    output logic                    p1_rdata_valid,
    output logic [DATA_WIDTH-1:0]   p1_rdata,
    input  logic                    avl_ready,
    output logic                    avl_burstbegin,
    output logic [ADDR_WIDTH-1:0]   avl_addr,
    output logic [DATA_WIDTH-1:0]   avl_wdata,
    output logic [DATA_WIDTH/8-1:0] avl_be,
    output logic                    avl_read_req,
    output logic                    avl_write_req,
    output logic [6:0]              avl_size,
    input  logic                    avl_rdata_valid,
    input  logic [DATA_WIDTH-1:0]   avl_rdata,
    output logic                    rd_orphan
);

    localparam int CNT_W = $clog2(RD_FIFO_DEPTH) + 1;

    arb_state_t              state;
    arb_state_t              state_nxt;
    logic                    rr_last;
    logic                    elig0;
    logic                    elig1;
    logic                    grant_vld;
    logic                    grant_id;
    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [DATA_WIDTH/8-1:0] sel_be;
    logic                    tag_push;
    logic                    tag_pop;
    logic                    tag_head;
    logic                    tag_full;
    logic                    tag_empty;
    logic [CNT_W-1:0]        tag_count;

    // Grant decision: only in IDLE; on a tie the port that did not win last time goes.
    always_comb begin
        elig0     = p0_cmd_valid & (p0_cmd_write | ~tag_full);
        elig1     = p1_cmd_valid & (p1_cmd_write | ~tag_full);
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state == IDLE) begin
            if (elig0 && elig1) begin
                grant_vld = 1'b1;
                grant_id  = ~rr_last;
            end else if (elig0) begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end else if (elig1) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = ISSUE;
            ISSUE:   if (avl_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Accept pulses are combinational; forced low while reset is asserted.
    always_comb begin
        p0_cmd_ready = reset_n & grant_vld & ~grant_id;
        p1_cmd_ready = reset_n & grant_vld & grant_id;
    end

    always_comb begin
        sel_write = grant_id ? p1_cmd_write : p0_cmd_write;
        sel_addr  = grant_id ? p1_cmd_addr  : p0_cmd_addr;
        sel_wdata = grant_id ? p1_cmd_wdata : p0_cmd_wdata;
        sel_be    = grant_id ? p1_cmd_be    : p0_cmd_be;
    end

    assign tag_push = grant_vld & ~sel_write;
    assign tag_pop  = avl_rdata_valid & ~tag_empty;

    arb_id_fifo #(
        .WIDTH (1),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (tag_push),
        .push_dat (grant_id),
        .pop      (tag_pop),
        .pop_dat  (tag_head),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (tag_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            rr_last        <= 1'b1;
            avl_burstbegin <= 1'b0;
            avl_addr       <= '0;
            avl_wdata      <= '0;
            avl_be         <= '0;
            avl_read_req   <= 1'b0;
            avl_write_req  <= 1'b0;
            avl_size       <= '0;
            p0_rdata_valid <= 1'b0;
            p1_rdata_valid <= 1'b0;
            p0_rdata       <= '0;
            p1_rdata       <= '0;
            rd_orphan      <= 1'b0;
        end else begin
            state          <= state_nxt;
            avl_size       <= AVL_SIZE_SINGLE;
            p0_rdata_valid <= tag_pop & ~tag_head;
            p1_rdata_valid <= tag_pop & tag_head;
            if (tag_pop && !tag_head) p0_rdata <= avl_rdata;
            if (tag_pop && tag_head)  p1_rdata <= avl_rdata;
            if (avl_rdata_valid && tag_empty) rd_orphan <= 1'b1;

            if (grant_vld) begin
                rr_last        <= grant_id;
                avl_addr       <= sel_addr;
                avl_wdata      <= sel_wdata;
                avl_be         <= sel_be;
                avl_burstbegin <= 1'b1;
                avl_read_req   <= ~sel_write;
                avl_write_req  <= sel_write;
            end else if (state == ISSUE) begin
                avl_burstbegin <= 1'b0;
                if (avl_ready) begin
                    avl_read_req  <= 1'b0;
                    avl_write_req <= 1'b0;
                end
            end
        end
    end

    tag_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
        tag_count <= CNT_W'(RD_FIFO_DEPTH));

endmodule
